// File: rtl/mem_req_completer.sv
// Memory-request completer: serves tagged read/write bursts against a single-port
// memory and returns read data as a tagged valid/ready completion stream.
module mem_req_completer #(
  parameter  int DEPTH      = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_LEN    = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = $clog2(MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [7:0]            req_tag,
  input  logic                  wr_data_valid,
  output logic                  wr_data_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpl_valid,
  input  logic                  cpl_ready,
  output logic [DATA_WIDTH-1:0] cpl_data,
  output logic [7:0]            cpl_tag,
  output logic                  cpl_last,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  err_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  LEN_MAX   = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  state_e                  state_q;
  state_e                  state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [LEN_WIDTH-1:0]    remain;
  logic [7:0]              tag_q;

  logic                    len_legal;
  logic                    req_take;
  logic                    wr_beat;
  logic                    cpl_load;
  logic                    cpl_pop;

  // Addresses wrap explicitly so non-power-of-two depths also work.
  assign next_addr = (cur_addr == LAST_ADDR) ? '0 : cur_addr + ADDR_WIDTH'(1);
  assign len_legal = (req_len != '0) && (req_len <= LEN_MAX);

  assign req_take  = (state_q == IDLE) && req_valid;
  assign wr_beat   = (state_q == WRITE) && wr_data_valid;
  assign cpl_pop   = cpl_valid && cpl_ready;

  // In READ, remain counts beats not yet loaded, so remain != 0 means issued < len.
  assign cpl_load  = (state_q == READ) && (!cpl_valid || cpl_ready) && (remain != '0);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    wr_data_ready = 1'b0;
    mem_wr_en     = 1'b0;
    mem_data_in   = '0;
    mem_address   = cur_addr;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && len_legal) begin
          state_d = req_is_write ? WRITE : READ;
        end
      end

      WRITE: begin
        wr_data_ready = 1'b1;
        mem_wr_en     = wr_data_valid;
        mem_data_in   = wr_data;
        if (wr_data_valid && (remain == LEN_ONE)) begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (cpl_pop && cpl_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr <= '0;
      remain   <= '0;
      tag_q    <= '0;
      err_len  <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (req_take) begin
        // Fields are captured even for a dropped request; they are unused until the next one.
        cur_addr <= req_addr;
        remain   <= req_len;
        tag_q    <= req_tag;
        err_len  <= !len_legal;
      end else if (wr_beat || cpl_load) begin
        cur_addr <= next_addr;
        remain   <= remain - LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpl_valid <= 1'b0;
      cpl_data  <= '0;
      cpl_tag   <= '0;
      cpl_last  <= 1'b0;
    end else if (cpl_load) begin
      cpl_valid <= 1'b1;
      cpl_data  <= mem_data_out;
      cpl_tag   <= tag_q;
      cpl_last  <= (remain == LEN_ONE);
    end else if (cpl_pop) begin
      cpl_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_completer.sv
// Bench for mem_req_completer: behavioural single-port memory, reference memory image,
// and a completion scoreboard filled when reads are issued and drained by a monitor.
module tb_mem_req_completer;

  localparam int DEPTH   = 32;
  localparam int DW      = 32;
  localparam int MAX_LEN = 8;
  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = $clog2(MAX_LEN) + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    tag;
    logic          last;
  } cpl_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [7:0]    req_tag;
  logic          wr_data_valid;
  logic          wr_data_ready;
  logic [DW-1:0] wr_data;
  logic          cpl_valid;
  logic          cpl_ready;
  logic [DW-1:0] cpl_data;
  logic [7:0]    cpl_tag;
  logic          cpl_last;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in;
  logic          mem_wr_en;
  logic [DW-1:0] mem_data_out;
  logic          err_len;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wbuf    [MAX_LEN];
  bit            mem_filled = 1'b0;
  cpl_t          exp_q [$];
  cpl_t          mon_got;
  cpl_t          mon_want;
  int            n_cmp  = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  mem_req_completer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .MAX_LEN(MAX_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_write  (req_is_write),
    .req_addr      (req_addr),
    .req_len       (req_len),
    .req_tag       (req_tag),
    .wr_data_valid (wr_data_valid),
    .wr_data_ready (wr_data_ready),
    .wr_data       (wr_data),
    .cpl_valid     (cpl_valid),
    .cpl_ready     (cpl_ready),
    .cpl_data      (cpl_data),
    .cpl_tag       (cpl_tag),
    .cpl_last      (cpl_last),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_wr_en     (mem_wr_en),
    .mem_data_out  (mem_data_out),
    .err_len       (err_len)
  );

  // Single-port memory: combinational read, synchronous write, preloaded on the first edge.
  assign mem_data_out = mem[mem_address];

  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hC000_0000 + 32'(i);
      mem_filled <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  // Completion monitor: a beat transfers at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (rst && cpl_valid && cpl_ready) begin
      mon_got = '{cpl_data, cpl_tag, cpl_last};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cpl_unexpected: got data=%h tag=%h last=%b, required no completion",
                 cpl_data, cpl_tag, cpl_last);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_fail++;
          $display("FAIL cpl_beat: got data=%h tag=%h last=%b, required data=%h tag=%h last=%b",
                   mon_got.data, mon_got.tag, mon_got.last,
                   mon_want.data, mon_want.tag, mon_want.last);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Presents one request across exactly one rising edge; callable from either clock phase.
  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [7:0] t);
    req_valid    = 1'b1;
    req_is_write = w;
    req_addr     = a;
    req_len      = l;
    req_tag      = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Write wbuf[0..len-1] at a; bit k of vpat is wr_data_valid in the k-th cycle after acceptance.
  task automatic do_write(input logic [AW-1:0] a, input int len, input logic [15:0] vpat,
                          input string name);
    logic [AW-1:0] addr;
    int            beat;
    int            cyc;
    logic          v;
    addr = a;
    beat = 0;
    cyc  = 0;
    send_req(1'b1, a, LW'(len), 8'h11);
    while (beat < len && cyc < 40) begin
      v             = (cyc < 16) ? vpat[cyc] : 1'b1;
      wr_data_valid = v;
      wr_data       = wbuf[beat];
      @(negedge clk);
      n_cmp++;
      if (wr_data_ready !== 1'b1 || mem_wr_en !== v ||
          (v && (mem_address !== addr || mem_data_in !== wbuf[beat]))) begin
        n_fail++;
        $display("FAIL %s_cyc%0d: got rdy=%b we=%b addr=%0d data=%h, required rdy=1 we=%b addr=%0d data=%h",
                 name, cyc, wr_data_ready, mem_wr_en, mem_address, mem_data_in,
                 v, addr, wbuf[beat]);
      end
      @(posedge clk); #1;
      if (v) begin
        ref_mem[addr] = wbuf[beat];
        addr          = wrap_inc(addr);
        beat++;
      end
      cyc++;
    end
    // Offer a stray beat: a block that has correctly returned to IDLE must ignore it.
    wr_data_valid = 1'b1;
    wr_data       = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (cyc >= 40 || req_ready !== 1'b1 || wr_data_ready !== 1'b0 || mem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: got cycles=%0d req_ready=%b wr_data_ready=%b we=%b, required cycles<40 1 0 0",
               name, cyc, req_ready, wr_data_ready, mem_wr_en);
    end
    wr_data_valid = 1'b0;
  endtask

  // Read len dwords at a; bit (k mod 4) of rp is cpl_ready in the k-th cycle after acceptance.
  task automatic do_read(input logic [AW-1:0] a, input int len, input logic [7:0] t,
                         input logic [3:0] rp, input string name);
    logic [AW-1:0] addr;
    int            cyc;
    logic          held_v;
    logic [DW+8:0] held;
    addr = a;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(cpl_t'{ref_mem[addr], t, (i == len - 1)});
      addr = wrap_inc(addr);
    end
    send_req(1'b0, a, LW'(len), t);
    cyc    = 0;
    held_v = 1'b0;
    held   = '0;
    while (exp_q.size() != 0 && cyc < 60) begin
      cpl_ready = rp[cyc % 4];
      @(negedge clk);
      if (cyc == 0) begin
        n_cmp++;
        if (cpl_valid !== 1'b0 || req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_lat0: got cpl_valid=%b req_ready=%b, required 0 0", name, cpl_valid, req_ready);
        end
      end
      if (cyc == 1) begin
        n_cmp++;
        if (cpl_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_lat1: got cpl_valid=%b, required 1", name, cpl_valid);
        end
      end
      if (held_v) begin
        n_cmp++;
        if ({cpl_valid, cpl_data, cpl_tag, cpl_last} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL %s_stall: got v=%b data=%h tag=%h last=%b, required held v=1 %h",
                   name, cpl_valid, cpl_data, cpl_tag, cpl_last, held);
        end
      end
      held_v = cpl_valid && !cpl_ready;
      held   = {cpl_data, cpl_tag, cpl_last};
      @(posedge clk); #1;
      cyc++;
    end
    cpl_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cyc >= 60 || exp_q.size() != 0 || cpl_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got cycles=%0d pending=%0d cpl_valid=%b req_ready=%b, required cycles<60 0 0 1",
               name, cyc, exp_q.size(), cpl_valid, req_ready);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpl_valid !== 1'b0 || cpl_last !== 1'b0 || cpl_data !== '0 || cpl_tag !== '0 ||
        err_len !== 1'b0 || mem_address !== '0 || mem_wr_en !== 1'b0 || wr_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: got v=%b last=%b data=%h tag=%h err=%b addr=%0d we=%b wrdy=%b, required all 0",
               cpl_valid, cpl_last, cpl_data, cpl_tag, err_len, mem_address, mem_wr_en, wr_data_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_write_then_read();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    do_write(5'd2, 4, 16'hFFFF, "wr_basic");
    do_read(5'd2, 4, 8'h22, 4'b1111, "rd_basic");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) wbuf[i] = 32'(i + 1);
    do_write(5'd30, 3, 16'hFFFF, "wr_wrap");
    do_read(5'd30, 3, 8'h33, 4'b1111, "rd_wrap");
  endtask

  task automatic test_backpressure();
    do_read(5'd8, 4, 8'h44, 4'b1001, "rd_bp");
    do_read(5'd28, MAX_LEN, 8'h45, 4'b0101, "rd_bp_max");
  endtask

  task automatic test_illegal_len();
    logic [LW-1:0] bad [2];
    bad[0] = '0;
    bad[1] = LW'(MAX_LEN + 1);
    wr_data_valid = 1'b1;
    wr_data       = 32'hBAD0_BAD0;
    cpl_ready     = 1'b1;
    for (int k = 0; k < 2; k++) begin
      send_req(k == 0, 5'd4, bad[k], 8'h5A);
      @(negedge clk);
      n_cmp++;
      if (err_len !== 1'b1 || req_ready !== 1'b1 || mem_wr_en !== 1'b0 || cpl_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse_len%0d: got err=%b req_ready=%b we=%b cpl_valid=%b, required 1 1 0 0",
                 bad[k], err_len, req_ready, mem_wr_en, cpl_valid);
      end
      @(negedge clk);
      n_cmp++;
      if (err_len !== 1'b0 || req_ready !== 1'b1 || mem_wr_en !== 1'b0 || cpl_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL err_after_len%0d: got err=%b req_ready=%b we=%b cpl_valid=%b, required 0 1 0 0",
                 bad[k], err_len, req_ready, mem_wr_en, cpl_valid);
      end
    end
    wr_data_valid = 1'b0;
    cpl_ready     = 1'b0;
    do_read(5'd4, 1, 8'h5B, 4'b1111, "rd_after_err");
  endtask

  task automatic test_write_gaps();
    wbuf[0] = 32'h1111_0001;
    wbuf[1] = 32'h2222_0002;
    wbuf[2] = 32'h3333_0003;
    do_write(5'd12, 3, 16'b0000_0000_0010_1001, "wr_gap");
    do_read(5'd12, 3, 8'h66, 4'b1111, "rd_gap");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < MAX_LEN; i++) wbuf[i] = 32'h5500_0000 + 32'(i * 3);
    do_write(5'd26, MAX_LEN, 16'hFFFF, "wr_b2b");
    do_read(5'd26, MAX_LEN, 8'h99, 4'b1011, "rd_b2b");
  endtask

  task automatic test_reset_mid_read();
    logic [AW-1:0] addr;
    int            cyc;
    addr = 5'd16;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(cpl_t'{ref_mem[addr], 8'h77, (i == 5)});
      addr = wrap_inc(addr);
    end
    send_req(1'b0, 5'd16, LW'(6), 8'h77);
    cpl_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 5 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc >= 20 || cpl_valid !== 1'b1 || cpl_data !== ref_mem[17]) begin
      n_fail++;
      $display("FAIL rst_mid_beat2: got cycles=%0d cpl_valid=%b data=%h, required cycles<20 1 %h",
               cyc, cpl_valid, cpl_data, ref_mem[17]);
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cpl_valid !== 1'b0 || req_ready !== 1'b1 || cpl_last !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: got cpl_valid=%b req_ready=%b last=%b, required 0 1 0",
               cpl_valid, req_ready, cpl_last);
    end
    cpl_ready = 1'b0;
    do_read(5'd16, 6, 8'h78, 4'b1111, "rd_after_rst");
  endtask

  initial begin
    req_valid     = 1'b0;
    req_is_write  = 1'b0;
    req_addr      = '0;
    req_len       = '0;
    req_tag       = '0;
    wr_data_valid = 1'b0;
    wr_data       = '0;
    cpl_ready     = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hC000_0000 + 32'(i);
    for (int i = 0; i < MAX_LEN; i++) wbuf[i] = '0;

    test_reset();
    test_write_then_read();
    test_wrap();
    test_backpressure();
    test_illegal_len();
    test_write_gaps();
    test_back_to_back();
    test_reset_mid_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_completer.md
# mem_req_completer

Memory-request completer for the transaction-layer memory model. It accepts tagged read/write requests of 1..MAX_LEN dwords and drives the single-port `MEM` helper through its address, data_in and wr_en port. Writes are taken beat-by-beat from a write-data stream. Reads are returned as a tagged completion stream with valid/ready backpressure. It is the requester-facing counterpart that owns the memory port.

## Interface
- `DEPTH`, 32, memory depth in dwords; must match the attached `MEM`
- `DATA_WIDTH`, 32, dword width
- `MAX_LEN`, 8, maximum dwords per request
- `ADDR_WIDTH`, $clog2(DEPTH), localparam
- `LEN_WIDTH`, $clog2(MAX_LEN)+1, localparam
- `clk` in 1 — the only clock
- `rst` in 1 — asynchronous, active-low reset
- `req_valid` in 1 — request present
- `req_ready` out 1 — request accepted when both high
- `req_is_write` in 1 — 1 = write, 0 = read
- `req_addr` in ADDR_WIDTH — start dword address
- `req_len` in LEN_WIDTH — dword count, legal range 1..MAX_LEN
- `req_tag` in 8 — returned on the completion
- `wr_data_valid` in 1, `wr_data_ready` out 1, `wr_data` in DATA_WIDTH — write-data stream
- `cpl_valid` out 1, `cpl_ready` in 1, `cpl_data` out DATA_WIDTH, `cpl_tag` out 8, `cpl_last` out 1 — read completion stream
- `mem_address` out ADDR_WIDTH, `mem_data_in` out DATA_WIDTH, `mem_wr_en` out 1, `mem_data_out` in DATA_WIDTH — connections to the `MEM` helper; `MEM` reads combinationally and writes synchronously
- `err_len` out 1 — one-cycle pulse when an illegal-length request is dropped

## Operation
- **FSM states:** IDLE, WRITE, READ.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, the block latches addr into `cur_addr`, latches len into `remain`, and latches tag.
  - If `req_len` == 0 or `req_len` > MAX_LEN: `err_len` = 1 for the next cycle, the request is dropped, and the FSM stays in IDLE.
  - Otherwise the FSM moves to WRITE or READ according to `req_is_write`.
- **WRITE**
  - `wr_data_ready` = 1.
  - `mem_wr_en` = `wr_data_valid` (combinational).
  - `mem_address` = `cur_addr`, `mem_data_in` = `wr_data`.
  - On each accepted beat: `cur_addr` += 1 modulo DEPTH, `remain` -= 1.
  - The FSM returns to IDLE on the beat where `remain` == 1.
  - `wr_data_valid` gaps stall the transfer without loss.
- **READ**
  - `mem_address` = `cur_addr`.
  - Output register load condition: (!`cpl_valid` || `cpl_ready`) && `issued` < len.
  - On load: `cpl_data` <= `mem_data_out`, `cpl_valid` <= 1, `cpl_tag` <= latched tag, `cpl_last` <= (this is the final beat); `cur_addr` advances with wrap.
  - If the output register is consumed and no beat is loaded, `cpl_valid` <= 0.
  - The FSM returns to IDLE in the cycle the beat with `cpl_last` is accepted.
- **Outputs outside their state:** `wr_data_ready` = 0 and `mem_wr_en` = 0 outside WRITE. `req_ready` = 0 outside IDLE.
- **Address wrap:** a request may cross the top of memory. Address DEPTH-1 is followed by address 0.
- **Request ordering:** requests are handled strictly one at a time, in order.
- **Read-after-write:** a read accepted in the cycle after a write's final beat returns the new data.

## Timing
- **Reset values:** state = IDLE, `cpl_valid` = 0, `cpl_last` = 0, `cpl_data` = 0, `cpl_tag` = 0, `err_len` = 0, `cur_addr` = 0. `req_ready` = 1 while `rst` is high after reset.
- **Reset mid-operation:** reset aborts immediately and returns to IDLE. Memory writes already committed remain. No completion is emitted for the aborted request.
- **Read latency:** a request accepted at edge T puts the FSM in READ during T+1. The first `cpl_valid` is seen after edge T+2.
- **Read throughput:** one beat per cycle while `cpl_ready` = 1.
- **Write timing:** each beat commits at the edge where `wr_data_valid` && `wr_data_ready`. With no gaps, a len-N write occupies N cycles after acceptance.
- **Completion stability:** `cpl_data`, `cpl_tag` and `cpl_last` are stable while `cpl_valid` && !`cpl_ready`.
- **Next request:** accepted at the earliest in the cycle after the FSM returns to IDLE.

## Test plan
- **Write then read:** write len 4 at addr 2 with data 0xA0..0xA3, tag 0x11. Then read len 4 at addr 2, tag 0x22.
  - Required: completions 0xA0, 0xA1, 0xA2, 0xA3, all with tag 0x22, `cpl_last` only on 0xA3, and the first `cpl_valid` two cycles after acceptance.
- **Wrap-around:** write len 3 at addr 30 with data 1, 2, 3, then read len 3 at addr 30.
  - Required: `mem_address` sequence 30, 31, 0; read returns 1, 2, 3.
- **Completion backpressure:** read len 4 with `cpl_ready` toggling 1,0,0,1,...
  - Required: no beat dropped or duplicated; data held stable while stalled.
- **Illegal length:** request with len 0, then a request with len MAX_LEN+1.
  - Required: `err_len` pulses once per request; no `mem_wr_en` asserted; no completion produced; `req_ready` stays 1.
- **Write-data gaps:** write len 3 with `wr_data_valid` pattern 1,0,0,1,0,1.
  - Required: exactly three `mem_wr_en` pulses at consecutive addresses; FSM back in IDLE after the third.
- **Reset mid-read:** assert `rst` low during beat 2 of a len-6 read.
  - Required: `cpl_valid` = 0 and `req_ready` = 1 after release. A subsequent read returns the original memory contents.
